// File: rtl/countdown_pkg.sv
// Shared state encoding and parameter defaults for the countdown timer.
// Imported by the timer top and its prescaler.
package countdown_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_PRESCALE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/countdown_timer_tick_gen.sv
// Prescaler: tick is combinational, high on the enabled cycle where the count equals prescale.
// Holds its count while en is low; clr returns it to zero. No backpressure.
module tick_gen
    import countdown_pkg::*;
#(
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] presc;

    assign tick = en & (presc == prescale);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (clr) begin
            presc <= '0;
        end else if (en) begin
            presc <= tick ? '0 : presc + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter: first expired pulse one cycle after edge load_val*(prescale+1) from accept.
// Start accepted only when idle and not aborting; pause freezes counting, abort cancels silently.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  reload_en,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  pause,
    input  logic                  abort,
    output logic [WIDTH-1:0]      cnt,
    output logic                  busy,
    output logic                  expired
);

    state_t                state;
    logic [WIDTH-1:0]      reload_val;
    logic                  reload_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic                  accept;
    logic                  count_en;
    logic                  tick;

    assign start_ready = (state == IDLE) & ~abort;
    assign accept      = start_valid & start_ready;
    // Counting is frozen for exactly as long as pause is high, so the edge that
    // leaves HOLD already advances; a tick can therefore never coincide with pause.
    assign count_en    = (state != IDLE) & ~pause;

    tick_gen #(
        .PRESCALE_W (PRESCALE_W)
    ) u_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (count_en),
        .clr      (abort | accept),
        .prescale (prescale_q),
        .tick     (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            expired    <= 1'b0;
            reload_val <= '0;
            reload_q   <= 1'b0;
            prescale_q <= '0;
        end else begin
            expired <= 1'b0;
            if (abort) begin
                state <= IDLE;
                cnt   <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            reload_val <= load_val;
                            reload_q   <= reload_en;
                            prescale_q <= prescale;
                            // A zero load expires immediately and never enters RUN.
                            if (load_val == '0) begin
                                expired <= 1'b1;
                                cnt     <= '0;
                            end else begin
                                cnt   <= load_val;
                                state <= RUN;
                                busy  <= 1'b1;
                            end
                        end
                    end
                    RUN, HOLD: begin
                        state <= pause ? HOLD : RUN;
                        if (tick) begin
                            if (cnt > WIDTH'(1)) begin
                                cnt <= cnt - WIDTH'(1);
                            end else begin
                                expired <= 1'b1;
                                if (reload_q) begin
                                    cnt <= reload_val;
                                end else begin
                                    cnt   <= '0;
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed plus random checks of countdown_timer against an elapsed-time reference model.
module tb_countdown_timer;

    localparam int WIDTH      = 8;
    localparam int PRESCALE_W = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start_valid;
    logic                  start_ready;
    logic [WIDTH-1:0]      load_val;
    logic                  reload_en;
    logic [PRESCALE_W-1:0] prescale;
    logic                  pause;
    logic                  abort;
    logic [WIDTH-1:0]      cnt;
    logic                  busy;
    logic                  expired;

    countdown_timer #(
        .WIDTH      (WIDTH),
        .PRESCALE_W (PRESCALE_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .load_val    (load_val),
        .reload_en   (reload_en),
        .prescale    (prescale),
        .pause       (pause),
        .abort       (abort),
        .cnt         (cnt),
        .busy        (busy),
        .expired     (expired)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a run is described by N, P, mode and the number of
    // unpaused active clocks elapsed since accept; count follows by division.
    bit m_active = 0;
    int m_n = 0, m_p = 0, m_e = 0, m_cnt = 0;
    bit m_reload = 0, m_exp = 0;

    int edge_idx, last_exp, n_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int t;
        m_exp = 0;
        if (abort) begin
            m_active = 0;
            m_cnt    = 0;
        end else if (!m_active) begin
            if (start_valid) begin
                if (load_val == 0) begin
                    m_exp = 1;
                    m_cnt = 0;
                end else begin
                    m_active = 1;
                    m_n      = int'(load_val);
                    m_p      = int'(prescale);
                    m_reload = reload_en;
                    m_e      = 0;
                    m_cnt    = m_n;
                end
            end
        end else if (!pause) begin
            m_e++;
            if (m_e % (m_p + 1) == 0) begin
                t = m_e / (m_p + 1);
                if (m_reload) begin
                    m_cnt = m_n - (t % m_n);
                    m_exp = (t % m_n == 0);
                end else if (t >= m_n) begin
                    m_cnt    = 0;
                    m_exp    = 1;
                    m_active = 0;
                end else begin
                    m_cnt = m_n - t;
                end
            end
        end
    endtask

    task automatic step();
        #1;
        chk("start_ready", start_ready, (!m_active && !abort) ? 1 : 0);
        @(posedge clk);
        model_edge();
        edge_idx++;
        #1;
        chk("cnt", cnt, m_cnt);
        chk("busy", busy, m_active);
        chk("expired", expired, m_exp);
        if (expired === 1'b1) begin
            last_exp = edge_idx;
            n_exp++;
        end
    endtask

    task automatic start(input int n, input int p, input bit rel);
        start_valid = 1'b1;
        load_val    = WIDTH'(n);
        prescale    = PRESCALE_W'(p);
        reload_en   = rel;
        edge_idx    = -1;
        last_exp    = -1;
        n_exp       = 0;
        step();
        start_valid = 1'b0;
        load_val    = WIDTH'($urandom_range(0, 255));
        prescale    = PRESCALE_W'($urandom_range(0, 15));
        reload_en   = ~rel;
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    initial begin
        rst_n = 1'b0; start_valid = 1'b0; load_val = '0; reload_en = 1'b0;
        prescale = '0; pause = 1'b0; abort = 1'b0;
        #3;
        chk("rst_cnt", cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_expired", expired, 0);
        chk("rst_ready", start_ready, 1);
        #9 rst_n = 1'b1;
        steps(2);

        // One-shot 5, prescale 0
        start(5, 0, 1'b0);
        chk("t1_cnt0", cnt, 5);
        steps(7);
        chk("t1_exp_edge", last_exp, 5);
        chk("t1_npulse", n_exp, 1);

        // One-shot 2, prescale 3
        start(2, 3, 1'b0);
        steps(10);
        chk("t2_exp_edge", last_exp, 8);
        chk("t2_npulse", n_exp, 1);

        // Reload 3, prescale 0
        start(3, 0, 1'b1);
        steps(10);
        chk("t3_npulse", n_exp, 3);
        chk("t3_busy", busy, 1);
        abort = 1'b1; step(); abort = 1'b0;

        // Pause for three cycles after edge 2
        start(4, 0, 1'b0);
        steps(2);
        chk("t4_cnt_pre", cnt, 2);
        pause = 1'b1; steps(3);
        chk("t4_cnt_hold", cnt, 2);
        pause = 1'b0; steps(4);
        chk("t4_exp_edge", last_exp, 7);

        // Abort at cnt 2 with a competing start
        start(4, 0, 1'b0);
        steps(2);
        abort = 1'b1; start_valid = 1'b1; load_val = 8'd6;
        step();
        abort = 1'b0; start_valid = 1'b0;
        chk("t5_cnt", cnt, 0);
        chk("t5_busy", busy, 0);
        chk("t5_npulse", n_exp, 0);
        steps(2);

        // Zero load expires immediately
        start(0, 2, 1'b1);
        chk("t6_exp_edge", last_exp, 0);
        steps(2);
        chk("t6_npulse", n_exp, 1);

        // Asynchronous reset mid-run
        start(5, 0, 1'b0);
        steps(2);
        chk("t7_cnt_pre", cnt, 3);
        #1 rst_n = 1'b0;
        #1;
        chk("t7_rst_cnt", cnt, 0);
        chk("t7_rst_busy", busy, 0);
        chk("t7_rst_expired", expired, 0);
        m_active = 0; m_cnt = 0; m_exp = 0;
        #2 rst_n = 1'b1;
        steps(2);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            abort       = ($urandom_range(0, 49) == 0);
            pause       = ($urandom_range(0, 5) == 0);
            start_valid = ($urandom_range(0, 2) == 0);
            load_val    = WIDTH'($urandom_range(0, 6));
            prescale    = PRESCALE_W'($urandom_range(0, 3));
            reload_en   = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
